// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller bus between pipeline datapath and controller
// master = pipeline/memory side, slave = hazard controller.
interface pipe_hazard_ctrl_if;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM, mem_ready;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, StallW;
  logic        FlushD, FlushE;
  logic        mem_req, mem_timeout;
  logic [31:0] stall_cycles, flush_count;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM, mem_ready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
    input  FlushD, FlushE, mem_req, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM, mem_ready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
    output FlushD, FlushE, mem_req, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard, forwarding and data-memory wait controller
// Optional statistics counters enabled by HAZARD_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              timeout_q, timeout_nxt;
  logic              mem_stall, mem_req_c, lw_stall;
  logic              stall_fd, flush_d, flush_e;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                         input logic wem, input logic [4:0] rdw,
                                         input logic wew);
    if (wem && rdm != 5'd0 && rdm == rs)      return 2'b10;
    else if (wew && rdw != 5'd0 && rdw == rs) return 2'b01;
    else                                      return 2'b00;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_nxt  = timeout_q;
    mem_stall    = 1'b0;
    mem_req_c    = 1'b0;
    case (state)
      IDLE: begin
        mem_req_c = hz.MemAccessM;
        if (hz.MemAccessM && !hz.mem_ready) begin
          mem_stall    = 1'b1;
          state_nxt    = WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end
      end
      WAIT: begin
        mem_req_c = 1'b1;
        if (hz.mem_ready) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt == CNT_W'(MAX_WAIT)) begin
            state_nxt   = ERR;
            timeout_nxt = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
          end
        end
      end
      ERR: begin
        // Hung memory: freeze everything and stop requesting until reset.
        mem_stall = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lw_stall = hz.LoadE && (hz.RdE != 5'd0) && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign stall_fd = lw_stall || mem_stall;
  assign flush_d  = hz.PCSrcE && !mem_stall;
  assign flush_e  = (lw_stall || hz.PCSrcE) && !mem_stall;

  // Outputs are forced quiet while reset is held, even though inputs may be live.
  assign hz.ForwardAE   = reset ? 2'b00 : fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.ForwardBE   = reset ? 2'b00 : fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.StallF      = !reset && stall_fd;
  assign hz.StallD      = !reset && stall_fd;
  assign hz.StallE      = !reset && mem_stall;
  assign hz.StallM      = !reset && mem_stall;
  assign hz.StallW      = !reset && mem_stall;
  assign hz.FlushD      = !reset && flush_d;
  assign hz.FlushE      = !reset && flush_e;
  assign hz.mem_req     = !reset && mem_req_c;
  assign hz.mem_timeout = timeout_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_fd) stall_q <= stall_q + 32'd1;
      if (flush_e)  flush_q <= flush_q + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
`else
  assign hz.stall_cycles = 32'd0;
  assign hz.flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
// Checks against a cycle model on every negedge plus hand-computed literal expectations.
module tb_pipe_hazard_ctrl;
  localparam int MW = 4;
`ifdef HAZARD_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_hazard_ctrl_if hz ();
  pipe_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(8)) dut (.clk(clk), .reset(reset), .hz(hz));

  always #5 clk = ~clk;

  // Model: age of the outstanding memory access (0 = none) and a dead flag for a hung memory.
  int          age;
  bit          dead;
  logic [31:0] m_stall, m_flush;

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
    if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_memstall();
    return dead || (age > 0 && !hz.mem_ready) || (age == 0 && hz.MemAccessM && !hz.mem_ready);
  endfunction

  function automatic bit m_lw();
    return hz.LoadE && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      age = 0; dead = 0; m_stall = 0; m_flush = 0;
    end else begin
      bit ms;
      ms = m_memstall();
      if (m_lw() || ms) m_stall = m_stall + 1;
      if ((m_lw() || hz.PCSrcE) && !ms) m_flush = m_flush + 1;
      if (!dead) begin
        if (age > 0) begin
          if (hz.mem_ready) age = 0;
          else if (age == MW) dead = 1;
          else age = age + 1;
        end else if (hz.MemAccessM && !hz.mem_ready) age = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [12:0] exp_v, act_v;
    bit ms, lw;
    ms = m_memstall();
    lw = m_lw();
    if (reset)
      exp_v = 13'd0;
    else
      exp_v = {fwd(hz.Rs1E), fwd(hz.Rs2E), lw || ms, lw || ms, ms, ms, ms,
               hz.PCSrcE && !ms, (lw || hz.PCSrcE) && !ms,
               dead ? 1'b0 : (age > 0 ? 1'b1 : hz.MemAccessM), dead};
    act_v = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW,
             hz.FlushD, hz.FlushE, hz.mem_req, hz.mem_timeout};
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model_outputs t=%0t actual=%b required=%b", $time, act_v, exp_v);
    end
    n_tests++;
    if (hz.stall_cycles !== (STATS_ON ? m_stall : 32'd0) ||
        hz.flush_count !== (STATS_ON ? m_flush : 32'd0)) begin
      n_fail++;
      $display("FAIL model_stats t=%0t actual=%0d/%0d required=%0d/%0d", $time,
               hz.stall_cycles, hz.flush_count, STATS_ON ? m_stall : 32'd0,
               STATS_ON ? m_flush : 32'd0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.LoadE = 0; hz.PCSrcE = 0;
    hz.MemAccessM = 0; hz.mem_ready = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    reset = 1'b1;
    // Live inputs during reset must not leak through.
    hz.RdM = 5; hz.Rs1E = 5; hz.RegWriteM = 1; hz.MemAccessM = 1; hz.PCSrcE = 1;
    #1;
    chk("rst_fwd", hz.ForwardAE, 2'b00);
    chk("rst_req", hz.mem_req, 0);
    chk("rst_flush", {hz.FlushD, hz.FlushE}, 0);
    cyc(); cyc();
    clr();
    reset = 1'b0;

    // Forwarding priority
    hz.RdM = 5; hz.RdW = 5; hz.Rs1E = 5; hz.RegWriteM = 1; hz.RegWriteW = 1; #1;
    chk("fwd_m", hz.ForwardAE, 2'b10);
    hz.RegWriteM = 0; #1;
    chk("fwd_w", hz.ForwardAE, 2'b01);
    hz.RdM = 0; hz.RdW = 0; #1;
    chk("fwd_x0", hz.ForwardAE, 2'b00);
    hz.Rs2E = 7; hz.RdW = 7; #1;
    chk("fwd_b_w", hz.ForwardBE, 2'b01);
    cyc();

    // Load-use: one stall cycle with bubble, then released
    clr(); hz.LoadE = 1; hz.RdE = 3; hz.Rs2D = 3; #1;
    chk("lu_stall", {hz.StallF, hz.StallD, hz.FlushE, hz.StallE, hz.FlushD}, 5'b11100);
    cyc();
    clr(); #1;
    chk("lu_release", {hz.StallF, hz.FlushE}, 2'b00);
    hz.LoadE = 1; hz.RdE = 0; hz.Rs1D = 0; #1;
    chk("lu_x0", hz.StallF, 0);
    cyc();

    // Load-use together with a redirect
    clr(); hz.LoadE = 1; hz.RdE = 3; hz.Rs1D = 3; hz.PCSrcE = 1; #1;
    chk("lu_branch", {hz.FlushD, hz.FlushE, hz.StallF, hz.StallD, hz.StallE}, 5'b11110);
    cyc();

    // Branch alone, then during a memory wait
    clr(); hz.PCSrcE = 1; #1;
    chk("br_flush", {hz.FlushD, hz.FlushE, hz.StallF, hz.StallE}, 4'b1100);
    cyc();
    hz.MemAccessM = 1; #1;
    chk("br_memwait", {hz.FlushD, hz.FlushE, hz.StallE, hz.mem_req}, 4'b0011);
    cyc(); cyc();
    chk("br_wait2", {hz.FlushD, hz.FlushE, hz.StallE}, 3'b001);
    hz.mem_ready = 1; #1;
    chk("br_ready", {hz.FlushD, hz.FlushE, hz.StallE, hz.mem_req}, 4'b1101);
    cyc();

    // Memory wait of three cycles, released on the fourth
    clr(); hz.MemAccessM = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_frozen%0d", i),
          {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW, hz.mem_req}, 6'b111111);
      cyc();
    end
    hz.mem_ready = 1; #1;
    chk("mw_ready", {hz.StallW, hz.mem_req}, 2'b01);
    cyc();
    clr(); #1;
    chk("mw_idle", {hz.mem_req, hz.StallF}, 2'b00);
    hz.MemAccessM = 1; hz.mem_ready = 1; #1;
    chk("mw_zero_wait", {hz.mem_req, hz.StallE}, 2'b10);
    cyc();

    // Timeout after MAX_WAIT+1 cycles, sticky and frozen
    clr(); hz.MemAccessM = 1;
    repeat (4) cyc();
    chk("to_early", hz.mem_timeout, 0);
    cyc();
    chk("to_set", hz.mem_timeout, 1);
    hz.MemAccessM = 0; hz.mem_ready = 1; #1;
    chk("to_frozen", {hz.StallF, hz.StallW, hz.mem_req, hz.FlushE}, 4'b1100);
    cyc(); cyc();
    chk("to_sticky", hz.mem_timeout, 1);
    reset = 1'b1; #1;
    chk("to_cleared", hz.mem_timeout, 0);
    cyc();
    clr();
    reset = 1'b0;

    // Statistics: load-use cycle then a branch cycle
    hz.LoadE = 1; hz.RdE = 3; hz.Rs2D = 3;
    cyc();
    clr(); hz.PCSrcE = 1;
    cyc();
    clr(); #1;
    chk("stat_stall", hz.stall_cycles, STATS_ON ? 32'd1 : 32'd0);
    chk("stat_flush", hz.flush_count, STATS_ON ? 32'd2 : 32'd0);

    // Reset in the middle of a wait drops the request and returns to idle
    hz.MemAccessM = 1;
    cyc();
    #2 reset = 1'b1; #1;
    chk("rst_wait_req", {hz.mem_req, hz.StallE}, 2'b00);
    cyc();
    clr();
    reset = 1'b0; #1;
    chk("rst_wait_idle", {hz.mem_req, hz.StallE}, 2'b00);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the stall and flush inputs of the F/D/E/M/W stage registers and the E-stage operand forwarding muxes. It also owns the data-memory request handshake, freezing the whole pipeline while a multi-cycle memory access is outstanding. A wait-timeout detects a hung memory.

Parameters:
MAX_WAIT, 16, maximum memory wait cycles before timeout (1..255)
CNT_W, 8, width of the wait counter (must hold MAX_WAIT)

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
Rs1D, Rs2D  in  5 each  source registers in D
Rs1E, Rs2E, RdE  in  5 each  sources/dest in E
RdM, RdW  in  5 each  dest in M/W
RegWriteM, RegWriteW  in  1 each  write-enable in M/W
LoadE  in  1  instruction in E is a load (ResultSrcE==01)
PCSrcE  in  1  taken branch or jump resolved in E
MemAccessM  in  1  load/store in M
mem_ready  in  1  data memory completes access this cycle
ForwardAE, ForwardBE  out  2 each  00 regfile, 10 from M, 01 from W
StallF, StallD, StallE, StallM, StallW  out  1 each  hold stage register
FlushD, FlushE  out  1 each  zero stage register (bubble)
mem_req  out  1  memory request
mem_timeout  out  1  sticky timeout flag
stall_cycles, flush_count  out  32 each  statistics (see Optional Feature)

Behaviour:
- Reset (async): state=IDLE, wait_cnt=0, mem_timeout=0. While reset is high, all stall/flush outputs are 0, Forward* are 00, and mem_req is 0.
- Forwarding (combinational): ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. ForwardBE uses the same rule on Rs2E. M has priority over W.
- lwStall = LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- memStall = (state==IDLE & MemAccessM & !mem_ready) | (state==WAIT & !mem_ready) | state==ERR.
- StallF = StallD = lwStall | memStall. StallE = StallM = StallW = memStall.
- FlushD = PCSrcE & !memStall. FlushE = (lwStall | PCSrcE) & !memStall. A flush is never asserted while frozen; it fires in the cycle the pipeline advances.
- FSM transitions:
  - IDLE: if MemAccessM & !mem_ready, go to WAIT with wait_cnt=1. Zero-wait access (ready in the same cycle) causes no stall.
  - WAIT: if mem_ready, go to IDLE with wait_cnt=0 (the pipeline advances on this edge). Else if wait_cnt==MAX_WAIT, go to ERR and set mem_timeout=1. Else wait_cnt+1.
  - ERR: absorbing until reset; the pipeline stays frozen; mem_req=0.
- mem_req = MemAccessM in IDLE; 1 in WAIT; 0 in ERR.
- Simultaneous lwStall and PCSrcE: FlushE=1, FlushD=1, StallF=StallD=1. The redirect wins at the PC mux, and the bubble covers E.
- Reset mid-WAIT returns the FSM to IDLE immediately and drops mem_req.

Optional Feature:
HAZARD_STATS_EN.
- Defined: stall_cycles increments on each cycle with StallF=1. flush_count increments on each cycle with FlushE=1. Both are 32-bit, wrap at 2^32-1 to 0, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
1. Forward priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. Set RegWriteM=0 -> ForwardAE=01. Set RdM=RdW=0 -> ForwardAE=00.
2. Load-use: LoadE=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for exactly one cycle; StallE=0.
3. Branch: PCSrcE=1 -> FlushD=FlushE=1 and no stalls. Repeat during a memory wait -> flushes stay 0 until mem_ready, then are 1 in that cycle.
4. Memory wait: MemAccessM=1 with mem_ready low for 3 cycles -> all Stall*=1 and mem_req=1 for 3 cycles. Release on the 4th cycle (ready=1) -> state returns to IDLE.
5. Timeout: MAX_WAIT=4, mem_ready held 0 -> mem_timeout=1 after 5 cycles; pipeline stays frozen; reset clears the flag.
6. HAZARD_STATS_EN: run test 2 then test 3 (no mem wait) -> stall_cycles=1, flush_count=2.
